load_sequencer: RTL and testbench

Controller that owns the 16-bit `loader` stage and shares it between two requesters. It accepts a word through a valid/ready handshake and drives `permit` and `values[1:16]` into the loader for a programmable number of hold cycles. It then enforces a settle gap before the next load and reports completion. Arbitration between the two requesters is round-robin.

---
 rtl/load_sequencer.sv | 135 +++++++++++++
 tb/tb_load_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_sequencer.sv
// load_sequencer: round-robin owner of the 16-bit loader stage.
// Captures a word, holds permit for HOLD_CYCLES, then settles for GAP_CYCLES.
module load_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [1:16] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [1:16] req1_data,
    output logic        req1_ready,
    output logic        permit,
    output logic [1:16] values,
    output logic        busy,
    output logic        grant_id,
    output logic        done
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last, last_n;
    logic          permit_n;
    logic [1:16]   values_n;
    logic          busy_n;
    logic          grant_n;
    logic          done_n;

    logic          win;
    logic          take;
    logic [1:16]   wdata;

    // Contention goes to whoever was not served last
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~last;
        end else begin
            win = req1_valid;
        end
    end

    assign take       = (state == IDLE) && !rst && (req0_valid || req1_valid);
    assign req0_ready = take && !win;
    assign req1_ready = take && win;
    assign wdata      = win ? req1_data : req0_data;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_n   = last;
        permit_n = permit;
        values_n = values;
        busy_n   = busy;
        grant_n  = grant_id;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    values_n = wdata;
                    grant_n  = win;
                    last_n   = win;
                    permit_n = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = HOLD_LD;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    permit_n = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        cnt_n   = GAP_LD;
                        state_n = GAP;
                    end else begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            permit   <= 1'b0;
            values   <= '0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last     <= last_n;
            permit   <= permit_n;
            values   <= values_n;
            busy     <= busy_n;
            grant_id <= grant_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Bench for load_sequencer: three configurations checked every cycle against
// a cycle-offset model, plus directed literal expectations.
module tb_load_sequencer;

    localparam int NI  = 3;
    localparam int BIG = 1000;

    function automatic int hof(input int k);
        if (k == 0) return 2;
        if (k == 1) return 1;
        return 3;
    endfunction

    function automatic int gof(input int k);
        if (k == 1) return 0;
        return 1;
    endfunction

    logic        clk;
    logic        rst    [NI];
    logic        v0     [NI];
    logic        v1     [NI];
    logic [1:16] d0     [NI];
    logic [1:16] d1     [NI];
    logic        rdy0   [NI];
    logic        rdy1   [NI];
    logic        permit [NI];
    logic [1:16] vals   [NI];
    logic        busy   [NI];
    logic        grant  [NI];
    logic        done   [NI];

    int          since  [NI];
    logic [1:16] mval   [NI];
    logic        mgrant [NI];
    logic        mlast  [NI];
    logic        known  [NI];

    int tests;
    int fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        load_sequencer #(
            .HOLD_CYCLES(hof(k)),
            .GAP_CYCLES (gof(k))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[k]),
            .req0_valid(v0[k]),
            .req0_data (d0[k]),
            .req0_ready(rdy0[k]),
            .req1_valid(v1[k]),
            .req1_data (d1[k]),
            .req1_ready(rdy1[k]),
            .permit    (permit[k]),
            .values    (vals[k]),
            .busy      (busy[k]),
            .grant_id  (grant[k]),
            .done      (done[k])
        );
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d t=%0t got %h expected %h",
                     nm, k, $time, act, exp);
        end
    endtask

    // Model: outputs follow from the number of cycles since the last handshake
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            int   h;
            int   g;
            int   s;
            logic idle;
            logic w;
            logic er0;
            logic er1;
            h    = hof(k);
            g    = gof(k);
            s    = since[k];
            idle = (s > h + g);
            w    = (v0[k] && v1[k]) ? !mlast[k] : v1[k];
            er0  = idle && !rst[k] && (v0[k] || v1[k]) && !w;
            er1  = idle && !rst[k] && (v0[k] || v1[k]) && w;
            if (known[k]) begin
                chk("m_permit", k, 32'(permit[k]), 32'(s >= 1 && s <= h));
                chk("m_busy", k, 32'(busy[k]), 32'(s >= 1 && s <= h + g));
                chk("m_done", k, 32'(done[k]), 32'(s == h + g + 1));
                chk("m_values", k, 32'(vals[k]), 32'(mval[k]));
                chk("m_grant", k, 32'(grant[k]), 32'(mgrant[k]));
                chk("m_ready0", k, 32'(rdy0[k]), 32'(er0));
                chk("m_ready1", k, 32'(rdy1[k]), 32'(er1));
            end
            if (rst[k]) begin
                since[k]  = BIG;
                mval[k]   = '0;
                mgrant[k] = 1'b0;
                mlast[k]  = 1'b1;
                known[k]  = 1'b1;
            end else if (er0 || er1) begin
                since[k]  = 1;
                mval[k]   = w ? d1[k] : d0[k];
                mgrant[k] = w;
                mlast[k]  = w;
            end else if (since[k] < BIG) begin
                since[k] = since[k] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int k = 0; k < NI; k++) begin
            rst[k]    = 1'b1;
            v0[k]     = 1'b0;
            v1[k]     = 1'b0;
            d0[k]     = '0;
            d1[k]     = '0;
            since[k]  = BIG;
            mval[k]   = '0;
            mgrant[k] = 1'b0;
            mlast[k]  = 1'b1;
            known[k]  = 1'b0;
        end
        ticks(2);
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;

        chk("rst_permit", 0, 32'(permit[0]), 32'h0);
        chk("rst_values", 0, 32'(vals[0]), 32'h0);
        chk("rst_busy", 0, 32'(busy[0]), 32'h0);
        chk("rst_grant", 0, 32'(grant[0]), 32'h0);
        chk("rst_done", 0, 32'(done[0]), 32'h0);

        // single load
        v0[0] = 1'b1;
        d0[0] = 16'hA5C3;
        #1;
        chk("t1_ready0", 0, 32'(rdy0[0]), 32'h1);
        tick();
        v0[0] = 1'b0;
        chk("t1_permit1", 0, 32'(permit[0]), 32'h1);
        chk("t1_values", 0, 32'(vals[0]), 32'hA5C3);
        chk("t1_busy1", 0, 32'(busy[0]), 32'h1);
        tick();
        chk("t1_permit2", 0, 32'(permit[0]), 32'h1);
        tick();
        chk("t1_permit3", 0, 32'(permit[0]), 32'h0);
        chk("t1_busy3", 0, 32'(busy[0]), 32'h1);
        tick();
        chk("t1_done4", 0, 32'(done[0]), 32'h1);
        chk("t1_busy4", 0, 32'(busy[0]), 32'h0);
        tick();
        chk("t1_done5", 0, 32'(done[0]), 32'h0);
        chk("t1_hold", 0, 32'(vals[0]), 32'hA5C3);

        // contention after reset
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        v0[0] = 1'b1;
        d0[0] = 16'h0001;
        v1[0] = 1'b1;
        d1[0] = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ready0", 0, 32'(rdy0[0]), 32'((i % 2) == 0));
            chk("t2_ready1", 0, 32'(rdy1[0]), 32'((i % 2) == 1));
            tick();
            if (i == 3) begin
                v0[0] = 1'b0;
                v1[0] = 1'b0;
            end
            chk("t2_values", 0, 32'(vals[0]),
                ((i % 2) == 0) ? 32'h0001 : 32'h8000);
            chk("t2_grant", 0, 32'(grant[0]), 32'(i % 2));
            ticks(3);
        end
        ticks(2);

        // back-to-back from req1 alone
        v1[0] = 1'b1;
        d1[0] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_ready1", 0, 32'(rdy1[0]), 32'h1);
            chk("t3_ready0", 0, 32'(rdy0[0]), 32'h0);
            if (i > 0) chk("t3_done", 0, 32'(done[0]), 32'h1);
            tick();
            if (i == 2) v1[0] = 1'b0;
            ticks(3);
        end
        ticks(2);

        // no gap, single hold cycle
        v0[1] = 1'b1;
        d0[1] = 16'h0F0F;
        tick();
        d0[1] = 16'hF0F0;
        #1;
        chk("t4_permit1", 1, 32'(permit[1]), 32'h1);
        chk("t4_ready_busy", 1, 32'(rdy0[1]), 32'h0);
        chk("t4_values", 1, 32'(vals[1]), 32'h0F0F);
        tick();
        chk("t4_permit2", 1, 32'(permit[1]), 32'h0);
        chk("t4_done2", 1, 32'(done[1]), 32'h1);
        chk("t4_ready2", 1, 32'(rdy0[1]), 32'h1);
        tick();
        v0[1] = 1'b0;
        chk("t4_values2", 1, 32'(vals[1]), 32'hF0F0);
        ticks(3);

        // reset mid-hold
        v0[2] = 1'b1;
        d0[2] = 16'hBEEF;
        tick();
        rst[2] = 1'b1;
        v0[2] = 1'b1;
        d0[2] = 16'h1111;
        v1[2] = 1'b1;
        d1[2] = 16'h2222;
        #1;
        chk("t5_values", 2, 32'(vals[2]), 32'hBEEF);
        chk("t5_rdy0_rst", 2, 32'(rdy0[2]), 32'h0);
        chk("t5_rdy1_rst", 2, 32'(rdy1[2]), 32'h0);
        tick();
        rst[2] = 1'b0;
        chk("t5_permit", 2, 32'(permit[2]), 32'h0);
        chk("t5_values0", 2, 32'(vals[2]), 32'h0);
        chk("t5_busy", 2, 32'(busy[2]), 32'h0);
        chk("t5_grant", 2, 32'(grant[2]), 32'h0);
        chk("t5_done", 2, 32'(done[2]), 32'h0);
        #1;
        chk("t5_win0", 2, 32'(rdy0[2]), 32'h1);
        tick();
        v0[2] = 1'b0;
        v1[2] = 1'b0;
        chk("t5_values1", 2, 32'(vals[2]), 32'h1111);
        ticks(6);

        // data changes while busy are ignored
        v0[0] = 1'b1;
        d0[0] = 16'hCAFE;
        tick();
        d0[0] = 16'hDEAD;
        chk("t6_v1", 0, 32'(vals[0]), 32'hCAFE);
        tick();
        d0[0] = 16'hBEEF;
        chk("t6_v2", 0, 32'(vals[0]), 32'hCAFE);
        tick();
        d0[0] = 16'h5A5A;
        chk("t6_v3", 0, 32'(vals[0]), 32'hCAFE);
        tick();
        chk("t6_v4", 0, 32'(vals[0]), 32'hCAFE);
        tick();
        v0[0] = 1'b0;
        chk("t6_v5", 0, 32'(vals[0]), 32'h5A5A);
        ticks(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
